// File: rtl/subckt_test_pkg.sv
// ---------------------------------------------------------------------------
// subckt_test_pkg
//   Shared definitions for the sub-circuit test sequencer.
//   - seq_state_t      : sequencer FSM states
//   - MISR_POLY/SEED   : signature register polynomial and start value
//   - *_DEF            : default values for the sequencer parameters
//   - misr_step()      : one MISR update for a single observed bit
// ---------------------------------------------------------------------------
package subckt_test_pkg;

   typedef enum logic [1:0] {
      ST_FLUSH = 2'd0,
      ST_READY = 2'd1,
      ST_HOLD  = 2'd2,
      ST_CHECK = 2'd3
   } seq_state_t;

   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'hFFFF;

   localparam int LATENCY_DEF      = 2;
   localparam int FLUSH_CYCLES_DEF = 2;
   localparam int CNT_W_DEF        = 16;

   // Shared wait counter covers both LATENCY and FLUSH_CYCLES (1..15).
   localparam int WAIT_W = 4;

   // Shift left; fold in the polynomial when the outgoing MSB and the new
   // observed bit disagree.
   function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                             input logic        din);
      logic [15:0] shifted;
      shifted = {sig[14:0], 1'b0};
      return (sig[15] ^ din) ? (shifted ^ MISR_POLY) : shifted;
   endfunction

endpackage

// File: rtl/subckt_test_sequencer_misr16.sv
// ---------------------------------------------------------------------------
// misr16
//   16-bit multiple-input signature register compacting one observed bit
//   per enabled cycle.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   synchronous active-low reset, loads the seed
//     clr    in   synchronous clear, loads the seed
//     en     in   advance the signature by one bit
//     din    in   observed bit
//     sig    out  current signature
// ---------------------------------------------------------------------------
module misr16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] sig
);
   import subckt_test_pkg::*;

   logic [15:0] sig_r;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         sig_r <= MISR_SEED;
      end else if (en) begin
         sig_r <= misr_step(sig_r, din);
      end
   end

   assign sig = sig_r;

endmodule

// File: rtl/subckt_test_sequencer.sv
// ---------------------------------------------------------------------------
// subckt_test_sequencer
//   Applies stimulus vectors to a small combinational/pipelined DUT, waits
//   LATENCY cycles, compares the DUT output with the golden value and keeps
//   a saturating error count plus a MISR signature of every sampled output.
//   Parameters:
//     LATENCY       cycles from dut_in change to valid dut_out (1..15)
//     FLUSH_CYCLES  cycles dut_rst_n is held low after reset/clear (1..15)
//     CNT_W         error counter width
//   Ports:
//     I1470_clk     in   clock, rising edge
//     I1477_rst     in   synchronous active-low reset
//     clr           in   clear statistics, abort current vector, re-flush
//     vec_valid     in   stimulus vector offered
//     vec_ready     out  vector accepted this cycle (READY state)
//     vec_data      in   4 stimulus bits
//     vec_expect    in   golden DUT output for vec_data
//     dut_in        out  registered DUT data drive
//     dut_rst_n     out  registered active-low DUT reset
//     dut_out       in   observed DUT output
//     res_valid     out  one-cycle result strobe
//     res_mismatch  out  dut_out != expected, qualified by res_valid
//     err_count     out  saturating mismatch count
//     signature     out  MISR over sampled dut_out bits
//     busy          out  high outside READY
// ---------------------------------------------------------------------------
module subckt_test_sequencer
   import subckt_test_pkg::*;
#(
   parameter int LATENCY      = LATENCY_DEF,
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic             I1470_clk,
   input  logic             I1477_rst,
   input  logic             clr,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  logic [3:0]       vec_data,
   input  logic             vec_expect,
   output logic [3:0]       dut_in,
   output logic             dut_rst_n,
   input  logic             dut_out,
   output logic             res_valid,
   output logic             res_mismatch,
   output logic [CNT_W-1:0] err_count,
   output logic [15:0]      signature,
   output logic             busy
);

   localparam logic [WAIT_W-1:0] LAT_LD   = WAIT_W'(LATENCY);
   localparam logic [WAIT_W-1:0] FLUSH_LD = WAIT_W'(FLUSH_CYCLES);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

   logic              rst_n;
   seq_state_t        state;
   seq_state_t        state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_nxt;
   logic              accept;
   logic              chk_fire;
   logic [3:0]        dut_in_p0;
   logic              exp_p0;
   logic              dut_rst_n_p0;
   logic [CNT_W-1:0]  err_cnt;

   assign rst_n = I1477_rst;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // State register; reset overrides clr and any handshake.
   always_ff @(posedge I1470_clk) begin
      if (!rst_n) begin
         state    <= ST_FLUSH;
         wait_cnt <= FLUSH_LD;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Next-state logic. One counter serves both the flush length and the
   // DUT settle time; the exit happens on the cycle it reads 1 so that each
   // state lasts exactly the loaded number of cycles.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      unique case (state)
         ST_FLUSH: begin
            if (wait_cnt == WAIT_ONE) begin
               state_nxt = ST_READY;
            end else begin
               wait_cnt_nxt = wait_cnt - WAIT_ONE;
            end
         end
         ST_READY: begin
            if (accept) begin
               state_nxt    = ST_HOLD;
               wait_cnt_nxt = LAT_LD;
            end
         end
         ST_HOLD: begin
            if (wait_cnt == WAIT_ONE) begin
               state_nxt = ST_CHECK;
            end else begin
               wait_cnt_nxt = wait_cnt - WAIT_ONE;
            end
         end
         ST_CHECK: begin
            state_nxt = ST_READY;
         end
         default: begin
            state_nxt    = ST_FLUSH;
            wait_cnt_nxt = FLUSH_LD;
         end
      endcase
      if (clr) begin
         state_nxt    = ST_FLUSH;
         wait_cnt_nxt = FLUSH_LD;
      end
   end

   // Output decode. The result strobe is masked by clr and by reset so an
   // aborted check never reports.
   always_comb begin
      vec_ready    = (state == ST_READY);
      busy         = (state != ST_READY);
      accept       = vec_valid && (state == ST_READY) && rst_n && !clr;
      chk_fire     = (state == ST_CHECK) && rst_n && !clr;
      res_valid    = chk_fire;
      res_mismatch = chk_fire && (dut_out ^ exp_p0);
   end

   // ---- stage p0: accepted vector drive and golden value ----
   always_ff @(posedge I1470_clk) begin
      if (!rst_n) begin
         dut_in_p0 <= 4'b0000;
      end else if (accept) begin
         dut_in_p0 <= vec_data;
      end
   end

   always_ff @(posedge I1470_clk) begin
      if (accept) begin
         exp_p0 <= vec_expect;
      end
   end

   // Registered DUT reset follows the state the FSM is about to enter, so it
   // is low exactly while the FSM sits in FLUSH.
   always_ff @(posedge I1470_clk) begin
      if (!rst_n) begin
         dut_rst_n_p0 <= 1'b0;
      end else begin
         dut_rst_n_p0 <= (state_nxt != ST_FLUSH);
      end
   end

   // ---- stage p1: result statistics ----
   always_ff @(posedge I1470_clk) begin
      if (!rst_n || clr) begin
         err_cnt <= '0;
      end else if (chk_fire && (dut_out ^ exp_p0)) begin
         err_cnt <= sat_inc(err_cnt);
      end
   end

   misr16 u_misr (
      .clk   (I1470_clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (chk_fire),
      .din   (dut_out),
      .sig   (signature)
   );

   assign dut_in    = dut_in_p0;
   assign dut_rst_n = dut_rst_n_p0;
   assign err_count = err_cnt;

endmodule

// File: tb/tb_subckt_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_subckt_test_sequencer
//   Directed bench for subckt_test_sequencer (LATENCY=2, FLUSH_CYCLES=2).
//   A 4-bit error counter keeps the saturation corner short.
// ---------------------------------------------------------------------------
module tb_subckt_test_sequencer;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr;
   logic          vec_valid;
   logic          vec_ready;
   logic [3:0]    vec_data;
   logic          vec_expect;
   logic [3:0]    dut_in;
   logic          dut_rst_n;
   logic          dut_out;
   logic          res_valid;
   logic          res_mismatch;
   logic [CW-1:0] err_count;
   logic [15:0]   signature;
   logic          busy;

   int            n_checks = 0;
   int            n_pass   = 0;
   int            cyc      = 0;
   logic [CW-1:0] m_err;
   logic [15:0]   m_sig;

   typedef struct {
      logic [3:0] d;
      logic       e;
      logic       o;
      logic       mm;
   } vec_t;

   vec_t tbl [6];

   always #5 clk = ~clk;

   subckt_test_sequencer #(
      .LATENCY      (2),
      .FLUSH_CYCLES (2),
      .CNT_W        (CW)
   ) dut (
      .I1470_clk    (clk),
      .I1477_rst    (rst_n),
      .clr          (clr),
      .vec_valid    (vec_valid),
      .vec_ready    (vec_ready),
      .vec_data     (vec_data),
      .vec_expect   (vec_expect),
      .dut_in       (dut_in),
      .dut_rst_n    (dut_rst_n),
      .dut_out      (dut_out),
      .res_valid    (res_valid),
      .res_mismatch (res_mismatch),
      .err_count    (err_count),
      .signature    (signature),
      .busy         (busy)
   );

   function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic d);
      logic fb;
      fb = s[15] ^ d;
      s  = s << 1;
      if (fb) s = s ^ 16'h1021;
      return s;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic model_result(input logic e, input logic o);
      if ((e != o) && (m_err != 4'hF)) m_err = m_err + 4'd1;
      m_sig = ref_misr(m_sig, o);
   endtask

   // Offer one vector in the current cycle and follow it to its result.
   // Returns with the bench sitting in the result cycle.
   task automatic run_vec(input logic [3:0] d, input logic e, input logic o,
                          output int hs_cyc, output int lat,
                          output logic mm, output logic [3:0] din_seen);
      int guard;
      hs_cyc   = cyc;
      lat      = -1;
      mm       = 1'b0;
      din_seen = 4'h0;
      vec_data = d; vec_expect = e; dut_out = o; vec_valid = 1'b1;
      #1;
      guard = 0;
      while (!vec_ready && guard < 20) begin
         step(); #1; guard++;
      end
      if (!vec_ready) begin
         chk("ready_timeout", 32'(0), 32'(1));
         vec_valid = 1'b0;
         return;
      end
      hs_cyc = cyc;
      step(); vec_valid = 1'b0; #1;
      guard = 0;
      while (!res_valid && guard < 20) begin
         step(); #1; guard++;
      end
      if (!res_valid) begin
         chk("result_timeout", 32'(0), 32'(1));
         return;
      end
      lat      = cyc - hs_cyc;
      mm       = res_mismatch;
      din_seen = dut_in;
      model_result(e, o);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int         hs, prev_hs, lat, rv;
      logic       mm;
      logic [3:0] dseen;

      tbl[0] = '{d: 4'b0110, e: 1'b0, o: 1'b0, mm: 1'b0};
      tbl[1] = '{d: 4'b0101, e: 1'b1, o: 1'b0, mm: 1'b1};
      tbl[2] = '{d: 4'b1111, e: 1'b1, o: 1'b0, mm: 1'b1};
      tbl[3] = '{d: 4'b0000, e: 1'b1, o: 1'b0, mm: 1'b1};
      tbl[4] = '{d: 4'b0011, e: 1'b0, o: 1'b1, mm: 1'b1};
      tbl[5] = '{d: 4'b1100, e: 1'b0, o: 1'b0, mm: 1'b0};

      rst_n = 1'b0; clr = 1'b0; vec_valid = 1'b0;
      vec_data = 4'h0; vec_expect = 1'b0; dut_out = 1'b0;
      m_err = '0; m_sig = 16'hFFFF;

      // Reset state
      step(); step(); #1;
      chk("rst_dut_in",       32'(dut_in),       32'(0));
      chk("rst_dut_rst_n",    32'(dut_rst_n),    32'(0));
      chk("rst_vec_ready",    32'(vec_ready),    32'(0));
      chk("rst_res_valid",    32'(res_valid),    32'(0));
      chk("rst_res_mismatch", 32'(res_mismatch), 32'(0));
      chk("rst_err_count",    32'(err_count),    32'(0));
      chk("rst_signature",    32'(signature),    32'(16'hFFFF));
      chk("rst_busy",         32'(busy),         32'(1));

      // Release with vec_valid held: two flush cycles, ready on the third
      step();
      rst_n = 1'b1; vec_valid = 1'b1; vec_data = 4'b1010; vec_expect = 1'b1; dut_out = 1'b1;
      #1;
      chk("flush1_dut_rst_n", 32'(dut_rst_n), 32'(0));
      chk("flush1_vec_ready", 32'(vec_ready), 32'(0));
      step(); #1;
      chk("flush2_dut_rst_n", 32'(dut_rst_n), 32'(0));
      chk("flush2_vec_ready", 32'(vec_ready), 32'(0));
      step(); #1;
      chk("ready3_vec_ready", 32'(vec_ready), 32'(1));
      chk("ready3_dut_rst_n", 32'(dut_rst_n), 32'(1));
      chk("ready3_busy",      32'(busy),      32'(0));
      chk("ready3_dut_in",    32'(dut_in),    32'(0));

      // First vector: matching output
      run_vec(4'b1010, 1'b1, 1'b1, hs, lat, mm, dseen);
      chk("v0_latency",  32'(lat),   32'(3));
      chk("v0_mismatch", 32'(mm),    32'(0));
      chk("v0_dut_in",   32'(dseen), 32'(4'b1010));
      prev_hs = hs;
      step(); #1;
      chk("v0_err_count", 32'(err_count), 32'(0));
      chk("v0_signature", 32'(signature), 32'(16'hFFFE));

      // Table of back-to-back vectors
      for (int i = 0; i < 6; i++) begin
         run_vec(tbl[i].d, tbl[i].e, tbl[i].o, hs, lat, mm, dseen);
         chk($sformatf("tbl%0d_latency", i),  32'(lat),     32'(3));
         chk($sformatf("tbl%0d_mismatch", i), 32'(mm),      32'(tbl[i].mm));
         chk($sformatf("tbl%0d_dut_in", i),   32'(dseen),   32'(tbl[i].d));
         chk($sformatf("tbl%0d_spacing", i),  32'(hs - prev_hs), 32'(4));
         prev_hs = hs;
         step(); #1;
         chk($sformatf("tbl%0d_err_count", i), 32'(err_count), 32'(m_err));
         chk($sformatf("tbl%0d_signature", i), 32'(signature), 32'(m_sig));
      end
      chk("tbl_err_total", 32'(err_count), 32'(4));

      // Saturation: walk up to all-ones-minus-one, then two more mismatches
      for (int k = 0; k < 10; k++) begin
         run_vec(4'b0101, 1'b1, 1'b0, hs, lat, mm, dseen);
         step(); #1;
      end
      chk("sat_pre", 32'(err_count), 32'(4'hE));
      run_vec(4'b0101, 1'b1, 1'b0, hs, lat, mm, dseen);
      step(); #1;
      chk("sat_reach", 32'(err_count), 32'(4'hF));
      run_vec(4'b0101, 1'b1, 1'b0, hs, lat, mm, dseen);
      chk("sat_mismatch_flag", 32'(mm), 32'(1));
      step(); #1;
      chk("sat_hold",      32'(err_count), 32'(4'hF));
      chk("sat_signature", 32'(signature), 32'(m_sig));

      // clr during HOLD
      vec_data = 4'b0110; vec_expect = 1'b1; dut_out = 1'b1; vec_valid = 1'b1;
      #1;
      chk("clrh_accept_ready", 32'(vec_ready), 32'(1));
      rv = 0;
      step(); vec_valid = 1'b0; clr = 1'b1; #1;
      rv += int'(res_valid);
      chk("clrh_dut_in_loaded", 32'(dut_in), 32'(4'b0110));
      step(); clr = 1'b0; #1;
      rv += int'(res_valid);
      chk("clrh_dut_rst_n1", 32'(dut_rst_n), 32'(0));
      chk("clrh_err_count",  32'(err_count), 32'(0));
      chk("clrh_signature",  32'(signature), 32'(16'hFFFF));
      chk("clrh_dut_in_hold", 32'(dut_in),   32'(4'b0110));
      step(); #1;
      rv += int'(res_valid);
      chk("clrh_dut_rst_n2", 32'(dut_rst_n), 32'(0));
      step(); #1;
      rv += int'(res_valid);
      chk("clrh_dut_rst_n3", 32'(dut_rst_n), 32'(1));
      chk("clrh_ready",      32'(vec_ready), 32'(1));
      chk("clrh_no_result",  32'(rv),        32'(0));
      m_err = '0; m_sig = 16'hFFFF;

      // clr coincident with a handshake wins
      vec_data = 4'b1001; vec_valid = 1'b1; clr = 1'b1; #1;
      step(); clr = 1'b0; vec_valid = 1'b0; #1;
      chk("clrhs_dut_in",    32'(dut_in),    32'(4'b0110));
      chk("clrhs_dut_rst_n", 32'(dut_rst_n), 32'(0));
      step(); step(); #1;
      chk("clrhs_ready", 32'(vec_ready), 32'(1));

      // clr in the result cycle suppresses the strobe and the count
      vec_data = 4'b0111; vec_expect = 1'b1; dut_out = 1'b0; vec_valid = 1'b1; #1;
      step(); vec_valid = 1'b0;
      step(); step(); clr = 1'b1; #1;
      chk("clrc_res_valid", 32'(res_valid), 32'(0));
      step(); clr = 1'b0; #1;
      chk("clrc_err_count", 32'(err_count), 32'(0));
      chk("clrc_signature", 32'(signature), 32'(16'hFFFF));
      step(); step(); #1;

      // MISR sequence 1,0,1,1 from the seed
      run_vec(4'b0001, 1'b1, 1'b1, hs, lat, mm, dseen); step(); #1;
      run_vec(4'b0001, 1'b1, 1'b0, hs, lat, mm, dseen); step(); #1;
      run_vec(4'b0001, 1'b1, 1'b1, hs, lat, mm, dseen); step(); #1;
      run_vec(4'b0001, 1'b1, 1'b1, hs, lat, mm, dseen); step(); #1;
      chk("misr_signature", 32'(signature), 32'(16'hBF74));
      chk("misr_err_count", 32'(err_count), 32'(1));

      // Reset mid-HOLD discards the pending result
      vec_data = 4'b1111; vec_expect = 1'b0; dut_out = 1'b0; vec_valid = 1'b1; #1;
      chk("rsth_ready", 32'(vec_ready), 32'(1));
      rv = 0;
      step(); vec_valid = 1'b0; rst_n = 1'b0; #1;
      rv += int'(res_valid);
      step(); rst_n = 1'b1; #1;
      chk("rsth_dut_rst_n", 32'(dut_rst_n), 32'(0));
      chk("rsth_dut_in",    32'(dut_in),    32'(0));
      chk("rsth_err_count", 32'(err_count), 32'(0));
      chk("rsth_signature", 32'(signature), 32'(16'hFFFF));
      chk("rsth_busy",      32'(busy),      32'(1));
      for (int k = 0; k < 5; k++) begin
         rv += int'(res_valid);
         step(); #1;
      end
      chk("rsth_no_result", 32'(rv), 32'(0));

      // Reset in the result cycle suppresses the strobe
      vec_data = 4'b0011; vec_expect = 1'b1; dut_out = 1'b1; vec_valid = 1'b1; #1;
      step(); vec_valid = 1'b0;
      step(); step(); rst_n = 1'b0; #1;
      chk("rstc_res_valid", 32'(res_valid), 32'(0));
      step(); rst_n = 1'b1; #1;
      chk("rstc_dut_rst_n", 32'(dut_rst_n), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
